// File: rtl/rx_block_buffer.sv
// rtl/rx_block_buffer.sv - receive-side byte-to-128-bit block packer with block FIFO
//
// Packs UART bytes into 128-bit plaintext blocks (first byte in [127:120])
// and queues whole blocks for the AES control block. The head block is
// presented first-word-fall-through; a partial block that sits idle for
// TIMEOUT_CYCLES clocks is discarded so the stream realigns to blocks.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low reset
//   rx_byte       received byte, qualified by rx_valid
//   rx_valid      one-cycle strobe for rx_byte
//   rx_read       pop the head block (ignored while rx_empty)
//   pt            head block, 0 when empty
//   rx_empty      no complete block queued
//   rx_full       DEPTH blocks queued
//   overflow      sticky: a completed block was dropped on a full FIFO
//   partial_level bytes held in the current partial block (0..15)

module rx_block_buffer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   rx_byte,
   input  logic         rx_valid,
   input  logic         rx_read,
   output logic [127:0] pt,
   output logic         rx_empty,
   output logic         rx_full,
   output logic         overflow,
   output logic [3:0]   partial_level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [TW-1:0] TLIM_C = TW'(TLIM);
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

   typedef enum logic {
      IDLE    = 1'b0,
      FILLING = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [3:0]    byte_cnt;
   // Bytes 0..14 of the block; byte 15 is taken straight from rx_byte at commit.
   logic [119:0]  asm_reg;
   logic [6:0]    asm_lsb;
   logic [127:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] tmo_cnt;
   logic          ovf_reg;

   logic          last_byte;
   logic          do_read;
   logic          do_commit;
   logic          do_drop;
   logic          expire;
   logic          tmo_inc;
   logic          tmo_clr;

   assign last_byte = rx_valid && (byte_cnt == 4'd15);
   assign do_read   = rx_read && (count != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_commit = last_byte && ((count != DEPTH_C) || do_read);
   assign do_drop   = last_byte && !do_commit;

   // Byte n of the block sits at bit (14-n)*8 of asm_reg.
   assign asm_lsb = {(4'd14 - byte_cnt), 3'b000};

   // ---------------------------------------------------------------
   // Timeout FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Timeout FSM: next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               state_nxt = FILLING;
            end
         end
         FILLING: begin
            if (last_byte || expire) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Timeout FSM: outputs
   // Expiry fires on the idle cycle that would bring the counter to
   // TIMEOUT_CYCLES; an rx_valid in that cycle wins over the discard.
   // ---------------------------------------------------------------
   always_comb begin
      expire  = 1'b0;
      tmo_inc = 1'b0;
      tmo_clr = 1'b0;
      case (state)
         IDLE: begin
            tmo_clr = 1'b1;
         end
         FILLING: begin
            if (rx_valid) begin
               tmo_clr = 1'b1;
            end else if (TO_EN) begin
               if (tmo_cnt == TLIM_C) begin
                  expire  = 1'b1;
                  tmo_clr = 1'b1;
               end else begin
                  tmo_inc = 1'b1;
               end
            end
         end
         default: tmo_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (tmo_clr) begin
         tmo_cnt <= '0;
      end else if (tmo_inc) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   // ---------------------------------------------------------------
   // Byte packing
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         byte_cnt <= 4'd0;
         asm_reg  <= '0;
      end else if (rx_valid) begin
         if (last_byte) begin
            byte_cnt <= 4'd0;
         end else begin
            asm_reg[asm_lsb +: 8] <= rx_byte;
            byte_cnt              <= byte_cnt + 4'd1;
         end
      end else if (expire) begin
         byte_cnt <= 4'd0;
      end
   end

   // ---------------------------------------------------------------
   // Block FIFO storage (contents survive reset; count gates visibility)
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset && do_commit) begin
         mem[wr_ptr] <= {asm_reg, rx_byte};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf_reg <= 1'b0;
      end else begin
         if (do_commit) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_commit, do_read})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (do_drop) begin
            ovf_reg <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs (registered state only; no path from rx_valid to pt)
   // ---------------------------------------------------------------
   assign rx_empty      = (count == '0);
   assign rx_full       = (count == DEPTH_C);
   assign pt            = rx_empty ? '0 : mem[rd_ptr];
   assign overflow      = ovf_reg;
   assign partial_level = byte_cnt;

endmodule

// File: tb/tb_rx_block_buffer.sv
// tb/tb_rx_block_buffer.sv - self-checking bench for rx_block_buffer

module tb_rx_block_buffer;

   localparam int DEPTH = 4;
   localparam int TMO   = 20;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   rx_byte = 8'd0;
   logic         rx_valid = 1'b0;
   logic         rx_read = 1'b0;
   logic [127:0] pt;
   logic         rx_empty;
   logic         rx_full;
   logic         overflow;
   logic [3:0]   partial_level;

   rx_block_buffer #(
      .DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_byte(rx_byte),
      .rx_valid(rx_valid),
      .rx_read(rx_read),
      .pt(pt),
      .rx_empty(rx_empty),
      .rx_full(rx_full),
      .overflow(overflow),
      .partial_level(partial_level)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: queue of whole blocks, queue of pending bytes,
   // sticky overflow flag and idle-cycle count since the last byte.
   logic [127:0] mq[$];
   logic [7:0]   part[$];
   bit           m_ovf = 1'b0;
   int           m_idle = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit rn, input bit v, input logic [7:0] b, input bit r);
      logic [127:0] blk;
      if (!rn) begin
         mq.delete();
         part.delete();
         m_ovf  = 1'b0;
         m_idle = 0;
         return;
      end
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (v) begin
         part.push_back(b);
         m_idle = 0;
         if (part.size() == 16) begin
            blk = '0;
            foreach (part[i]) blk = {blk[119:0], part[i]};
            if (mq.size() < DEPTH) mq.push_back(blk);
            else m_ovf = 1'b1;
            part.delete();
         end
      end else if (part.size() > 0) begin
         m_idle++;
         if (TMO > 0 && m_idle == TMO) begin
            part.delete();
            m_idle = 0;
         end
      end
   endtask

   task automatic check_state(input string tag);
      logic [127:0] e;
      e = (mq.size() > 0) ? mq[0] : '0;
      chk({tag, ".empty"}, rx_empty, mq.size() == 0);
      chk({tag, ".full"}, rx_full, mq.size() == DEPTH);
      chk({tag, ".pt"}, pt, e);
      chk({tag, ".ovf"}, overflow, m_ovf);
      chk({tag, ".level"}, partial_level, part.size());
   endtask

   // One clock: drive, advance the model at the edge, check at negedge.
   task automatic cyc(input bit rn, input bit v, input logic [7:0] b, input bit r, input string tag);
      reset    = rn;
      rx_valid = v;
      rx_byte  = b;
      rx_read  = r;
      @(posedge clk);
      model_step(rn, v, b, r);
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_read  = 1'b0;
      check_state(tag);
   endtask

   task automatic idle(input int n, input string tag);
      repeat (n) cyc(1'b1, 1'b0, 8'h00, 1'b0, tag);
   endtask

   task automatic send_block(input logic [127:0] blk, input string tag);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, blk[127 - 8*i -: 8], 1'b0, tag);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   logic [127:0] exp_blk [5];
   logic [127:0] r128;
   logic [127:0] blk;

   initial begin
      // Reset
      cyc(1'b0, 1'b0, 8'h00, 1'b0, "reset");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, "reset");
      chk("reset.pt0", pt, 128'h0);
      chk("reset.empty1", rx_empty, 1'b1);
      chk("reset.level0", partial_level, 4'd0);

      // Single block, one byte every 3 cycles
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b1, 8'(i), 1'b0, "single");
         if (i < 15) idle(2, "single.gap");
      end
      chk("single.pt_const", pt, 128'h000102030405060708090A0B0C0D0E0F);
      chk("single.not_empty", rx_empty, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, "single.read");
      chk("single.pt_after_read", pt, 128'h0);
      chk("single.empty_after_read", rx_empty, 1'b1);

      // Fill and overflow
      for (int k = 0; k < 5; k++) begin
         r128 = rand128();
         exp_blk[k] = {8'(8'hA0 + k), r128[119:0]};
         send_block(exp_blk[k], "fill");
         if (k == 3) chk("fill.full_after4", rx_full, 1'b1);
         if (k == 3) chk("fill.ovf_after4", overflow, 1'b0);
         if (k == 4) chk("fill.ovf_after5", overflow, 1'b1);
      end
      for (int k = 0; k < 4; k++) begin
         chk("fill.head_byte", pt[127:120], 8'(8'hA0 + k));
         chk("fill.head_blk", pt, exp_blk[k]);
         cyc(1'b1, 1'b0, 8'h00, 1'b1, "fill.read");
      end
      chk("fill.ovf_sticky", overflow, 1'b1);
      chk("fill.drained", rx_empty, 1'b1);

      // Simultaneous commit and read while full
      cyc(1'b0, 1'b0, 8'h00, 1'b0, "sim.reset");
      for (int k = 0; k < 5; k++) exp_blk[k] = rand128();
      for (int k = 0; k < 4; k++) send_block(exp_blk[k], "sim.fill");
      chk("sim.full", rx_full, 1'b1);
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, exp_blk[4][127 - 8*i -: 8], 1'b0, "sim.b5");
      cyc(1'b1, 1'b1, exp_blk[4][7:0], 1'b1, "sim.commit_read");
      chk("sim.still_full", rx_full, 1'b1);
      chk("sim.no_ovf", overflow, 1'b0);
      for (int k = 1; k < 5; k++) begin
         chk("sim.order", pt, exp_blk[k]);
         cyc(1'b1, 1'b0, 8'h00, 1'b1, "sim.read");
      end
      chk("sim.drained", rx_empty, 1'b1);

      // Timeout discard
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'($urandom()), 1'b0, "tmo.part");
      idle(TMO - 1, "tmo.wait");
      chk("tmo.level_before", partial_level, 4'd5);
      idle(1, "tmo.expire");
      chk("tmo.level_after", partial_level, 4'd0);
      chk("tmo.no_block", rx_empty, 1'b1);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, "tmo.block");
      chk("tmo.pt_const", pt, 128'h101112131415161718191A1B1C1D1E1F);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, "tmo.read");
      // Byte arriving on the expiry cycle wins
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'($urandom()), 1'b0, "race.part");
      idle(TMO - 1, "race.wait");
      cyc(1'b1, 1'b1, 8'h5A, 1'b0, "race.byte");
      chk("race.level", partial_level, 4'd4);
      idle(TMO, "race.expire");
      chk("race.level_after", partial_level, 4'd0);

      // Reset mid-operation
      send_block(rand128(), "rst.b0");
      send_block(rand128(), "rst.b1");
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 8'($urandom()), 1'b0, "rst.part");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, "rst.pulse");
      chk("rst.empty", rx_empty, 1'b1);
      chk("rst.full", rx_full, 1'b0);
      chk("rst.ovf", overflow, 1'b0);
      chk("rst.level", partial_level, 4'd0);
      chk("rst.pt", pt, 128'h0);
      blk = rand128();
      send_block(blk, "rst.fresh");
      chk("rst.fresh_pt", pt, blk);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, "rst.read");

      // Empty read is ignored
      cyc(1'b1, 1'b0, 8'h00, 1'b1, "eread");
      chk("eread.empty", rx_empty, 1'b1);
      chk("eread.pt", pt, 128'h0);
      blk = rand128();
      send_block(blk, "eread.block");
      chk("eread.pt_blk", pt, blk);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, "eread.read");
      chk("eread.drained", rx_empty, 1'b1);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            idle(TMO + $urandom_range(0, 5), "rand.long_idle");
         end else begin
            cyc(($urandom_range(0, 999) != 0),
                ($urandom_range(0, 99) < 45),
                8'($urandom()),
                ($urandom_range(0, 99) < 25),
                "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
